// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 encodings and the lsu_axi_master state type
package axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [2:0] AXI_SIZE_B = 3'd0;
  localparam logic [2:0] AXI_SIZE_H = 3'd1;
  localparam logic [2:0] AXI_SIZE_W = 3'd2;
  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW_W, ST_B} lsu_axi_state_t;
endpackage

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: single-outstanding LSU-to-AXI4 bridge (req_* in, resp_* out, m_* single-beat AR/R/AW/W/B master)
module lsu_axi_master
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0] req_wstrb,
  input  logic [2:0] req_size,
  output logic resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic resp_err,
  output logic [ADDR_W-1:0] m_araddr,
  output logic m_arvalid,
  input  logic m_arready,
  output logic [3:0] m_arid,
  output logic [7:0] m_arlen,
  output logic [2:0] m_arsize,
  output logic [1:0] m_arburst,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0] m_rresp,
  input  logic m_rvalid,
  output logic m_rready,
  input  logic m_rlast,
  input  logic [3:0] m_rid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic m_awvalid,
  input  logic m_awready,
  output logic [3:0] m_awid,
  output logic [7:0] m_awlen,
  output logic [2:0] m_awsize,
  output logic [1:0] m_awburst,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0] m_wstrb,
  output logic m_wvalid,
  input  logic m_wready,
  output logic m_wlast,
  input  logic [1:0] m_bresp,
  input  logic m_bvalid,
  output logic m_bready,
  input  logic [3:0] m_bid
);
  lsu_axi_state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] wdata, wdata_n, rdata, rdata_n;
  logic [3:0] strb, strb_n;
  logic [2:0] size, size_n;
  logic arvalid, arvalid_n, rready, rready_n, awvalid, awvalid_n, wvalid, wvalid_n;
  logic bready, bready_n, rvalid_q, rvalid_n, err, err_n, aw_done, aw_done_n, w_done, w_done_n;
  logic unused_ok;
  assign unused_ok = ^{m_rlast, m_rid, m_bid, m_rresp[0], m_bresp[0]};
  assign req_ready = state == ST_IDLE;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata;
  assign resp_err = err;
  assign m_araddr = addr;
  assign m_arvalid = arvalid;
  assign m_arid = AXI_ID;
  assign m_arlen = 8'd0;
  assign m_arsize = size;
  assign m_arburst = AXI_BURST_INCR;
  assign m_rready = rready;
  assign m_awaddr = addr;
  assign m_awvalid = awvalid;
  assign m_awid = AXI_ID;
  assign m_awlen = 8'd0;
  assign m_awsize = size;
  assign m_awburst = AXI_BURST_INCR;
  assign m_wdata = wdata;
  assign m_wstrb = strb;
  assign m_wvalid = wvalid;
  assign m_wlast = 1'b1;
  assign m_bready = bready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      {addr, wdata, rdata, strb, size} <= '0;
      {arvalid, rready, awvalid, wvalid, bready, rvalid_q, err, aw_done, w_done} <= '0;
    end else begin
      state <= state_n;
      {addr, wdata, rdata, strb, size} <= {addr_n, wdata_n, rdata_n, strb_n, size_n};
      {arvalid, rready, awvalid, wvalid, bready, rvalid_q, err, aw_done, w_done} <=
        {arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n, rvalid_n, err_n, aw_done_n, w_done_n};
    end
  end
  always_comb begin
    state_n = state;
    {addr_n, wdata_n, rdata_n, strb_n, size_n} = {addr, wdata, rdata, strb, size};
    {arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n} = {arvalid, rready, awvalid, wvalid, bready};
    {err_n, aw_done_n, w_done_n} = {err, aw_done, w_done};
    rvalid_n = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) begin
        {addr_n, wdata_n, strb_n, size_n} = {req_addr, req_wdata, req_wstrb, req_size};
        state_n = req_wen ? ST_AW_W : ST_AR;
        {awvalid_n, wvalid_n, arvalid_n} = {req_wen, req_wen, !req_wen};
      end
      ST_AR: if (m_arready) begin
        {arvalid_n, rready_n} = 2'b01;
        state_n = ST_R;
      end
      ST_R: if (m_rvalid) begin
        {rready_n, rvalid_n, err_n} = {1'b0, 1'b1, m_rresp[1]};
        rdata_n = m_rdata;
        state_n = ST_IDLE;
      end
      ST_AW_W: begin
        // Each channel completes independently; done flags include this cycle's handshake.
        awvalid_n = awvalid && !m_awready;
        wvalid_n = wvalid && !m_wready;
        aw_done_n = aw_done || (awvalid && m_awready);
        w_done_n = w_done || (wvalid && m_wready);
        if (aw_done_n && w_done_n) begin
          {bready_n, aw_done_n, w_done_n} = 3'b100;
          state_n = ST_B;
        end
      end
      ST_B: if (m_bvalid) begin
        {bready_n, rvalid_n, err_n} = {1'b0, 1'b1, m_bresp[1]};
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master: directed and randomized bench with a cycle-level slave and latency/response model
module tb_lsu_axi_master;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_wen = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_wstrb = 0;
  logic [2:0] req_size = 0;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] m_araddr, m_rdata = 0, m_awaddr, m_wdata;
  logic m_arvalid, m_arready = 0, m_rvalid = 0, m_rready, m_rlast = 1;
  logic [3:0] m_arid, m_rid = 0, m_awid, m_wstrb, m_bid = 0;
  logic [7:0] m_arlen, m_awlen;
  logic [2:0] m_arsize, m_awsize;
  logic [1:0] m_arburst, m_rresp = 0, m_awburst, m_bresp = 0;
  logic m_awvalid, m_awready = 0, m_wvalid, m_wready = 0, m_wlast, m_bvalid = 0, m_bready;
  int errors = 0, checks = 0;
  logic [31:0] last_rd = 0;
  lsu_axi_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One transaction from the idle cycle to its response cycle. For loads d is the slave's read data.
  // Response cycle = 3 + address wait + data/B wait (store: the slower of AW and W).
  task automatic txn(input bit wen, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [2:0] sz, input int d_a, input int d_w, input int d_x,
                     input logic [1:0] resp, input bit hold);
    int exp_t, a_t, w_t;
    bit a_done, w_done, x_done;
    exp_t = wen ? 3 + (d_a > d_w ? d_a : d_w) + d_x : 3 + d_a + d_x;
    a_t = 0; w_t = 0; a_done = 0; w_done = 0; x_done = 0;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_wen = wen; req_addr = a; req_wstrb = s; req_size = sz;
    req_wdata = wen ? d : $urandom;
    {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
    @(negedge clk);
    req_valid = hold;
    for (int t = 1; t <= exp_t; t++) begin
      chk("req_ready", req_ready, t == exp_t);
      chk("resp_valid", resp_valid, t == exp_t);
      if (!wen) begin
        chk("arvalid", m_arvalid, !a_done);
        chk("rready", m_rready, a_done && !x_done);
        chk("wr_chan_idle", {m_awvalid, m_wvalid, m_bready}, 0);
        if (m_arvalid) begin
          chk("araddr", m_araddr, a);
          chk("arsize", m_arsize, sz);
          chk("ar_const", {m_arid, m_arlen, m_arburst}, {4'h0, 8'h0, 2'b01});
        end
        m_rvalid = a_done && !x_done && t >= a_t + 1 + d_x;
        m_rdata = m_rvalid ? d : $urandom;
        m_rresp = resp;
        if (m_rvalid && m_rready) x_done = 1;
        m_arready = !a_done && t >= 1 + d_a;
        if (m_arready && m_arvalid) begin a_done = 1; a_t = t; end
      end else begin
        chk("awvalid", m_awvalid, !a_done);
        chk("wvalid", m_wvalid, !w_done);
        chk("bready", m_bready, a_done && w_done && !x_done);
        chk("rd_chan_idle", {m_arvalid, m_rready}, 0);
        if (m_awvalid) begin
          chk("awaddr", m_awaddr, a);
          chk("awsize", m_awsize, sz);
          chk("aw_const", {m_awid, m_awlen, m_awburst}, {4'h0, 8'h0, 2'b01});
        end
        if (m_wvalid) chk("w_payload", {m_wdata, m_wstrb, m_wlast}, {d, s, 1'b1});
        m_bvalid = a_done && w_done && !x_done && t >= (a_t > w_t ? a_t : w_t) + 1 + d_x;
        m_bresp = resp;
        if (m_bvalid && m_bready) x_done = 1;
        m_awready = !a_done && t >= 1 + d_a;
        m_wready = !w_done && t >= 1 + d_w;
        if (m_awready && m_awvalid) begin a_done = 1; a_t = t; end
        if (m_wready && m_wvalid) begin w_done = 1; w_t = t; end
      end
      if (t == exp_t) begin
        chk("resp_err", resp_err, resp[1]);
        chk("resp_rdata", resp_rdata, wen ? last_rd : d);
      end else @(negedge clk);
    end
    if (!wen) last_rd = d;
  endtask
  task automatic idle_check();
    @(negedge clk);
    chk("no_extra_pulse", resp_valid, 0);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_handshakes", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_valid, resp_err}, 0);
    chk("rst_rdata", resp_rdata, 0);
    rst = 0;
    @(negedge clk);
    txn(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0, 3'd2, 2, 0, 0, 2'b00, 0);
    idle_check();
    txn(1, 32'h8000_0020, 32'h1234_5678, 4'hF, 3'd2, 2, 0, 0, 2'b00, 0);
    idle_check();
    txn(1, 32'h8000_0024, 32'hA5A5_0F0F, 4'h3, 3'd1, 0, 0, 4, 2'b00, 0);
    idle_check();
    txn(1, 32'h8000_0028, 32'h0BAD_F00D, 4'h1, 3'd0, 0, 3, 1, 2'b11, 0);
    idle_check();
    txn(0, 32'h8000_0030, 32'h0000_CAFE, 4'h0, 3'd2, 0, 0, 1, 2'b10, 0);
    idle_check();
    txn(0, 32'h8000_0040, 32'h1111_2222, 4'h0, 3'd2, 0, 0, 0, 2'b00, 1);
    txn(1, 32'h8000_0044, 32'h3333_4444, 4'hC, 3'd2, 0, 0, 0, 2'b00, 0);
    idle_check();
    for (int i = 0; i < 24; i++) begin
      bit w, h;
      w = 1'($urandom % 2);
      h = (i < 23) && ($urandom % 3 == 0);
      txn(w, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), 3'($urandom_range(0, 2)),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), h);
      if (!h) idle_check();
    end
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0050;
    @(negedge clk);
    req_valid = 0;
    m_arready = 1;
    @(negedge clk);
    m_arready = 0;
    chk("pre_rst_rready", m_rready, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_handshakes", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_resp", resp_valid, 0);
    @(negedge clk);
    chk("post_rst_resp", resp_valid, 0);
    chk("post_rst_req_ready", req_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
